// File: rtl/store_xlate_stage.sv
// store_xlate_stage: holds one store/AMO/shadow-stack request during DTLB translation,
// re-aligns its data and queues translated stores ahead of the store/AMO buffers.
module store_xlate_stage #(
  parameter  int DATA_W     = 64,
  parameter  int VLEN       = 39,
  parameter  int PLEN       = 56,
  parameter  int TRANS_ID_W = 3,
  parameter  int DEPTH      = 4,
  localparam int BE_W       = DATA_W / 8,
  localparam int OFF_W      = $clog2(BE_W),
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [VLEN-1:0]       vaddr_i,
  input  logic [DATA_W-1:0]     data_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [1:0]            size_i,
  input  logic                  amo_i,
  input  logic                  ss_i,
  input  logic [TRANS_ID_W-1:0] trans_id_i,
  output logic                  translation_req_o,
  output logic [VLEN-1:0]       vaddr_o,
  input  logic                  dtlb_hit_i,
  input  logic [PLEN-1:0]       paddr_i,
  input  logic                  ex_valid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [PLEN-1:0]       out_paddr_o,
  output logic [DATA_W-1:0]     out_data_o,
  output logic [BE_W-1:0]       out_be_o,
  output logic [1:0]            out_size_o,
  output logic                  out_amo_o,
  output logic                  out_ss_o,
  output logic                  wb_valid_o,
  output logic [TRANS_ID_W-1:0] wb_trans_id_o,
  output logic                  wb_ex_o,
  output logic [AW:0]           count_o,
  output logic                  empty_o
);
  typedef enum logic [1:0] {IDLE, XLATE, WAIT_FULL} state_t;
  typedef struct packed {
    logic [PLEN-1:0]   paddr;
    logic [DATA_W-1:0] data;
    logic [BE_W-1:0]   be;
    logic [1:0]        size;
    logic              amo;
    logic              ss;
  } entry_t;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  state_t state, state_n;
  entry_t mem [DEPTH];
  entry_t head, fresh;
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic [VLEN-1:0] h_vaddr;
  logic [DATA_W-1:0] h_data, rot;
  logic [2*DATA_W-1:0] dd;
  logic [BE_W-1:0] h_be;
  logic [1:0] h_size;
  logic h_amo, h_ss, amo_q;
  logic [TRANS_ID_W-1:0] h_id;
  logic busy, slot_free, complete, enq, deq, accept;
  always_comb begin
    dd = {data_i, data_i} << {vaddr_i[OFF_W-1:0], 3'b000};
    rot = dd[2*DATA_W-1:DATA_W];
    busy = state != IDLE;
    deq = count != '0 && out_ready_i;
    slot_free = count != FULL || out_ready_i;
    complete = busy && dtlb_hit_i && (ex_valid_i || slot_free);
    enq = complete && !ex_valid_i && !flush_i;
    // an AMO owns the path from acceptance until it leaves the queue
    ready_o = !rst_i && !flush_i && !((busy && h_amo) || amo_q) && (!busy || complete)
              && (!amo_i || count == '0);
    accept = valid_i && ready_o;
    state_n = flush_i ? IDLE : accept ? XLATE : complete ? IDLE
            : (state == XLATE && dtlb_hit_i) ? WAIT_FULL : state;
    fresh = '{paddr: paddr_i, data: h_data, be: h_be, size: h_size, amo: h_amo, ss: h_ss};
    head = count != '0 ? mem[rd] : '0;
  end
  assign translation_req_o = busy;
  assign vaddr_o = h_vaddr;
  assign out_valid_o = count != '0;
  assign out_paddr_o = head.paddr;
  assign out_data_o = head.data;
  assign out_be_o = head.be;
  assign out_size_o = head.size;
  assign out_amo_o = head.amo;
  assign out_ss_o = head.ss;
  assign count_o = count;
  assign empty_o = count == '0 && !busy;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      wr <= '0;
      rd <= '0;
      count <= '0;
      amo_q <= 1'b0;
      h_vaddr <= '0;
      h_data <= '0;
      h_be <= '0;
      h_size <= '0;
      h_amo <= 1'b0;
      h_ss <= 1'b0;
      h_id <= '0;
      wb_valid_o <= 1'b0;
      wb_trans_id_o <= '0;
      wb_ex_o <= 1'b0;
    end else begin
      state <= state_n;
      wb_valid_o <= complete && !flush_i;
      wb_trans_id_o <= h_id;
      wb_ex_o <= complete && ex_valid_i && !flush_i;
      if (accept) begin
        h_vaddr <= vaddr_i;
        h_data <= amo_i ? data_i : rot;
        h_be <= be_i;
        h_size <= size_i;
        h_amo <= amo_i;
        h_ss <= ss_i;
        h_id <= trans_id_i;
      end
      if (flush_i) begin
        wr <= '0;
        rd <= '0;
        count <= '0;
        amo_q <= 1'b0;
      end else begin
        if (enq) wr <= wr + 1'b1;
        if (deq) rd <= rd + 1'b1;
        count <= count + {{AW{1'b0}}, enq} - {{AW{1'b0}}, deq};
        if (enq && h_amo) amo_q <= 1'b1;
        else if (deq && mem[rd].amo) amo_q <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (enq) mem[wr] <= fresh;
  end
endmodule

// File: tb/tb_store_xlate_stage.sv
// tb_store_xlate_stage: directed vector table plus hand-written sequences for
// back-pressure, delayed/faulting translation, AMO ordering, flush and async reset.
module tb_store_xlate_stage;
  logic clk_i = 1'b0, rst_i = 1'b1, flush_i = 1'b0, valid_i = 1'b0, ready_o;
  logic [38:0] vaddr_i = '0, vaddr_o;
  logic [63:0] data_i = '0, out_data_o;
  logic [7:0] be_i = '0, out_be_o;
  logic [1:0] size_i = '0, out_size_o;
  logic amo_i = 1'b0, ss_i = 1'b0, out_amo_o, out_ss_o;
  logic [2:0] trans_id_i = '0, wb_trans_id_o, count_o;
  logic translation_req_o, dtlb_hit_i = 1'b0, ex_valid_i = 1'b0;
  logic [55:0] paddr_i = '0, out_paddr_o;
  logic out_valid_o, out_ready_i = 1'b0, wb_valid_o, wb_ex_o, empty_o;
  int checks = 0, errors = 0;

  store_xlate_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .vaddr_i(vaddr_i), .data_i(data_i), .be_i(be_i), .size_i(size_i), .amo_i(amo_i),
    .ss_i(ss_i), .trans_id_i(trans_id_i), .translation_req_o(translation_req_o),
    .vaddr_o(vaddr_o), .dtlb_hit_i(dtlb_hit_i), .paddr_i(paddr_i), .ex_valid_i(ex_valid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_paddr_o(out_paddr_o),
    .out_data_o(out_data_o), .out_be_o(out_be_o), .out_size_o(out_size_o),
    .out_amo_o(out_amo_o), .out_ss_o(out_ss_o), .wb_valid_o(wb_valid_o),
    .wb_trans_id_o(wb_trans_id_o), .wb_ex_o(wb_ex_o), .count_o(count_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [38:0] vaddr;
    logic [63:0] data;
    logic [7:0]  be;
    logic [1:0]  size;
    logic        amo;
    logic [55:0] paddr;
    logic [63:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic req(input logic [38:0] va, input logic [63:0] d, input logic [7:0] be,
                     input logic [1:0] sz, input logic amo, input logic ss, input logic [2:0] id);
    valid_i = 1'b1; vaddr_i = va; data_i = d; be_i = be; size_i = sz;
    amo_i = amo; ss_i = ss; trans_id_i = id;
  endtask

  task automatic idle_in;
    valid_i = 1'b0; amo_i = 1'b0; ss_i = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vt[i];
    out_ready_i = 1'b0; dtlb_hit_i = 1'b0; ex_valid_i = 1'b0;
    req(v.vaddr, v.data, v.be, v.size, v.amo, 1'b0, 3'(i));
    #1 chk("vec_ready", 64'(ready_o), 64'd1);
    tick;
    idle_in; dtlb_hit_i = 1'b1; paddr_i = v.paddr;
    #1 chk("vec_treq", 64'(translation_req_o), 64'd1);
    chk("vec_vaddr_o", 64'(vaddr_o), 64'(v.vaddr));
    chk("vec_ready_held", 64'(ready_o), 64'(!v.amo));
    tick;
    dtlb_hit_i = 1'b0;
    #1 chk("vec_wb_valid", 64'(wb_valid_o), 64'd1);
    chk("vec_wb_id", 64'(wb_trans_id_o), 64'(i));
    chk("vec_wb_ex", 64'(wb_ex_o), 64'd0);
    chk("vec_out_valid", 64'(out_valid_o), 64'd1);
    chk("vec_out_data", out_data_o, v.exp);
    chk("vec_out_paddr", 64'(out_paddr_o), 64'(v.paddr));
    chk("vec_out_be", 64'(out_be_o), 64'(v.be));
    chk("vec_out_amo", 64'(out_amo_o), 64'(v.amo));
    chk("vec_count", 64'(count_o), 64'd1);
    out_ready_i = 1'b1;
    tick;
    out_ready_i = 1'b0;
    #1 chk("vec_wb_once", 64'(wb_valid_o), 64'd0);
    chk("vec_drained", 64'(empty_o), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{39'h1003, 64'hAB, 8'h08, 2'd0, 1'b0, 56'h8000_1003, 64'h0000_0000_AB00_0000};
    vt[1] = '{39'h2006, 64'h1234, 8'hC0, 2'd1, 1'b0, 56'h8000_2006, 64'h1234_0000_0000_0000};
    vt[2] = '{39'h3004, 64'hDEAD_BEEF, 8'hF0, 2'd2, 1'b0, 56'h8000_3004, 64'hDEAD_BEEF_0000_0000};
    vt[3] = '{39'h4000, 64'h0123_4567_89AB_CDEF, 8'hFF, 2'd3, 1'b0, 56'h8000_4000, 64'h0123_4567_89AB_CDEF};
    vt[4] = '{39'h5005, 64'h1122_3344_5566_7788, 8'hFF, 2'd3, 1'b0, 56'h8000_5005, 64'h6677_8811_2233_4455};
    vt[5] = '{39'h6004, 64'hCAFE_F00D, 8'hF0, 2'd2, 1'b1, 56'h8000_6004, 64'h0000_0000_CAFE_F00D};

    // reset state
    tick;
    chk("rst_empty", 64'(empty_o), 64'd1);
    chk("rst_ready", 64'(ready_o), 64'd0);
    chk("rst_count", 64'(count_o), 64'd0);
    chk("rst_wb", 64'(wb_valid_o), 64'd0);
    chk("rst_treq", 64'(translation_req_o), 64'd0);
    rst_i = 1'b0;
    tick;

    for (int i = 0; i < 6; i++) run_vec(i);

    // full queue: fifth store waits until a slot frees
    out_ready_i = 1'b0; dtlb_hit_i = 1'b1; paddr_i = 56'h9000_0000;
    for (int i = 0; i < 5; i++) begin
      req(39'h1000 + 39'(8 * i), 64'h100 + 64'(i), 8'hFF, 2'd3, 1'b0, 1'b0, 3'(i));
      #1 chk("full_accept", 64'(ready_o), 64'd1);
      tick;
    end
    idle_in;
    #1 chk("full_count", 64'(count_o), 64'd4);
    chk("full_ready", 64'(ready_o), 64'd0);
    tick;
    chk("full_wait_treq", 64'(translation_req_o), 64'd1);
    chk("full_wait_ready", 64'(ready_o), 64'd0);
    chk("full_wait_wb", 64'(wb_valid_o), 64'd0);
    out_ready_i = 1'b1;
    #1 chk("full_free_ready", 64'(ready_o), 64'd1);
    tick;
    out_ready_i = 1'b0; dtlb_hit_i = 1'b0;
    #1 chk("full_count_kept", 64'(count_o), 64'd4);
    chk("full_wb", 64'(wb_valid_o), 64'd1);
    chk("full_wb_id", 64'(wb_trans_id_o), 64'd4);
    chk("full_head", out_data_o, 64'h101);
    chk("full_idle", 64'(translation_req_o), 64'd0);
    tick;
    chk("full_wb_once", 64'(wb_valid_o), 64'd0);
    out_ready_i = 1'b1;
    repeat (4) tick;
    out_ready_i = 1'b0;
    chk("full_drained", 64'(empty_o), 64'd1);

    // translation delayed three cycles, then faults
    req(39'h3000, 64'h5A, 8'h01, 2'd0, 1'b0, 1'b0, 3'd5);
    #1 chk("ex_accept", 64'(ready_o), 64'd1);
    tick;
    idle_in;
    for (int c = 0; c < 3; c++) begin
      #1 chk("ex_treq_wait", 64'(translation_req_o), 64'd1);
      tick;
    end
    dtlb_hit_i = 1'b1; ex_valid_i = 1'b1;
    #1 chk("ex_treq_last", 64'(translation_req_o), 64'd1);
    tick;
    dtlb_hit_i = 1'b0; ex_valid_i = 1'b0;
    #1 chk("ex_wb", 64'(wb_valid_o), 64'd1);
    chk("ex_wb_ex", 64'(wb_ex_o), 64'd1);
    chk("ex_wb_id", 64'(wb_trans_id_o), 64'd5);
    chk("ex_count", 64'(count_o), 64'd0);
    chk("ex_idle", 64'(translation_req_o), 64'd0);

    // AMO waits for an empty queue and blocks later stores until dequeued
    out_ready_i = 1'b0; dtlb_hit_i = 1'b1; paddr_i = 56'h9000_0100;
    req(39'h100, 64'h1, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd1);
    #1 tick;
    req(39'h108, 64'h2, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd2);
    #1 tick;
    req(39'h204, 64'h55, 8'hF0, 2'd2, 1'b1, 1'b0, 3'd3);
    #1 chk("amo_block_c1", 64'(ready_o), 64'd0);
    tick;
    chk("amo_count2", 64'(count_o), 64'd2);
    chk("amo_block_c2", 64'(ready_o), 64'd0);
    out_ready_i = 1'b1;
    tick;
    chk("amo_block_drain", 64'(ready_o), 64'd0);
    tick;
    chk("amo_accept", 64'(ready_o), 64'd1);
    tick;
    req(39'h300, 64'h3, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd4);
    #1 chk("amo_held_block", 64'(ready_o), 64'd0);
    tick;
    out_ready_i = 1'b0;
    #1 chk("amo_queued_block", 64'(ready_o), 64'd0);
    chk("amo_head_amo", 64'(out_amo_o), 64'd1);
    chk("amo_head_data", out_data_o, 64'h55);
    chk("amo_head_count", 64'(count_o), 64'd1);
    tick;
    out_ready_i = 1'b1;
    #1 chk("amo_deq_block", 64'(ready_o), 64'd0);
    tick;
    chk("amo_released", 64'(ready_o), 64'd1);
    tick;
    idle_in;
    repeat (2) tick;
    out_ready_i = 1'b0;
    chk("amo_drained", 64'(empty_o), 64'd1);

    // shadow-stack push, then flush with three queued and one completing
    paddr_i = 56'h9000_2000;
    req(39'h2000, 64'h77, 8'hFF, 2'd3, 1'b0, 1'b1, 3'd6);
    #1 tick;
    req(39'h2008, 64'h78, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd7);
    #1 tick;
    req(39'h2010, 64'h79, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd0);
    #1 chk("ss_head", 64'(out_ss_o), 64'd1);
    tick;
    req(39'h2018, 64'h7A, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd1);
    #1 tick;
    idle_in; flush_i = 1'b1;
    #1 chk("flush_ready", 64'(ready_o), 64'd0);
    chk("flush_pre_count", 64'(count_o), 64'd3);
    tick;
    flush_i = 1'b0; dtlb_hit_i = 1'b0;
    #1 chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_empty", 64'(empty_o), 64'd1);
    chk("flush_wb", 64'(wb_valid_o), 64'd0);
    chk("flush_out_valid", 64'(out_valid_o), 64'd0);
    tick;
    chk("flush_wb_later", 64'(wb_valid_o), 64'd0);

    // asynchronous reset mid-translation with a non-empty queue
    dtlb_hit_i = 1'b1; paddr_i = 56'h9000_7000;
    req(39'h7000, 64'h11, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd2);
    #1 tick;
    req(39'h7008, 64'h22, 8'hFF, 2'd3, 1'b0, 1'b0, 3'd3);
    #1 tick;
    idle_in; dtlb_hit_i = 1'b0;
    #1 chk("pre_rst_count", 64'(count_o), 64'd1);
    chk("pre_rst_treq", 64'(translation_req_o), 64'd1);
    rst_i = 1'b1;
    #1 chk("arst_count", 64'(count_o), 64'd0);
    chk("arst_empty", 64'(empty_o), 64'd1);
    chk("arst_treq", 64'(translation_req_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd0);
    chk("arst_out_valid", 64'(out_valid_o), 64'd0);
    chk("arst_out_data", out_data_o, 64'd0);
    chk("arst_vaddr_o", 64'(vaddr_o), 64'd0);
    chk("arst_wb", 64'(wb_valid_o), 64'd0);
    tick;
    rst_i = 1'b0;
    tick;
    run_vec(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
